// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter.
// Imported by mem_arbiter; holds FSM state and owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between CPU and debug/loader for the single-port memory.
// Accesses are serialised: grant, LAT strobe cycles, a done cycle, then one idle cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LAT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t            state, state_next;
  owner_t            last_owner, last_owner_next;
  owner_t            win;
  logic              grant;
  logic              we_sel;
  logic [3:0]        cnt, cnt_next;
  logic              cpu_gnt_next, cpu_done_next, dbg_gnt_next, dbg_done_next;
  logic              mem_rd_next, mem_wr_next, busy_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next, cpu_rdata_next, dbg_rdata_next;

  // Next-state and next-output computation for the whole access sequence
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    cnt_next        = cnt;
    cpu_gnt_next    = cpu_gnt;
    cpu_done_next   = cpu_done;
    cpu_rdata_next  = cpu_rdata;
    dbg_gnt_next    = dbg_gnt;
    dbg_done_next   = dbg_done;
    dbg_rdata_next  = dbg_rdata;
    mem_rd_next     = mem_rd;
    mem_wr_next     = mem_wr;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    win             = OWN_CPU;
    grant           = 1'b0;
    we_sel          = 1'b0;

    case (state)
      IDLE: begin
        // CPU wins a tie only when the debug port owned the previous access
        if (cpu_req && (!dbg_req || last_owner == OWN_DBG)) begin
          grant = 1'b1;
          win   = OWN_CPU;
        end else if (dbg_req) begin
          grant = 1'b1;
          win   = OWN_DBG;
        end else begin
          grant = 1'b0;
          win   = OWN_CPU;
        end

        if (grant) begin
          we_sel          = (win == OWN_CPU) ? cpu_we : dbg_we;
          mem_addr_next   = (win == OWN_CPU) ? cpu_addr : dbg_addr;
          mem_wdata_next  = (win == OWN_CPU) ? cpu_wdata : dbg_wdata;
          mem_rd_next     = !we_sel;
          mem_wr_next     = we_sel;
          cpu_gnt_next    = (win == OWN_CPU);
          dbg_gnt_next    = (win == OWN_DBG);
          last_owner_next = win;
          cnt_next        = CNT_LOAD;
          state_next      = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end

      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          if (mem_rd && last_owner == OWN_CPU) begin
            cpu_rdata_next = mem_rdata;
          end else if (mem_rd) begin
            dbg_rdata_next = mem_rdata;
          end else begin
            cpu_rdata_next = cpu_rdata;
          end
          if (last_owner == OWN_CPU) begin
            cpu_done_next = 1'b1;
          end else begin
            dbg_done_next = 1'b1;
          end
          state_next = DONE;
        end
      end

      DONE: begin
        cpu_done_next = 1'b0;
        dbg_done_next = 1'b0;
        cpu_gnt_next  = 1'b0;
        dbg_gnt_next  = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next      = IDLE;
        last_owner_next = OWN_DBG;
        cnt_next        = 4'd0;
        cpu_gnt_next    = 1'b0;
        cpu_done_next   = 1'b0;
        cpu_rdata_next  = '0;
        dbg_gnt_next    = 1'b0;
        dbg_done_next   = 1'b0;
        dbg_rdata_next  = '0;
        mem_rd_next     = 1'b0;
        mem_wr_next     = 1'b0;
        mem_addr_next   = '0;
        mem_wdata_next  = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset drops every strobe immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWN_DBG;
      cnt        <= 4'd0;
      cpu_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      dbg_gnt    <= 1'b0;
      dbg_done   <= 1'b0;
      dbg_rdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      cnt        <= cnt_next;
      cpu_gnt    <= cpu_gnt_next;
      cpu_done   <= cpu_done_next;
      cpu_rdata  <= cpu_rdata_next;
      dbg_gnt    <= dbg_gnt_next;
      dbg_done   <= dbg_done_next;
      dbg_rdata  <= dbg_rdata_next;
      mem_rd     <= mem_rd_next;
      mem_wr     <= mem_wr_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LAT=2 and a LAT=1 instance, each with a small memory,
// checked every cycle against a timeline model plus directed literal checks.
module tb_mem_arbiter;

  logic clock;
  logic reset;

  logic [1:0]      cpu_req, cpu_we, dbg_req, dbg_we;
  logic [1:0][4:0] cpu_addr, dbg_addr, mem_addr;
  logic [1:0][7:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
  logic [1:0]      cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_rd, mem_wr, busy;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] init_val(input logic [4:0] a);
    if (a == 5'h1F) return 8'hA5;
    else return {3'b000, a} ^ 8'h3C;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int GL = (g == 0) ? 2 : 1;
    logic [7:0] mem [32];
    logic [3:0] rd_age;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .LAT(GL)) u_dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]), .dbg_wdata(dbg_wdata[g]),
      .dbg_gnt(dbg_gnt[g]), .dbg_done(dbg_done[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Memory: read data is only correct in the last strobe cycle
    always @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_val(5'(i));
        rd_age <= 4'd0;
      end else begin
        if (mem_wr[g]) mem[mem_addr[g]] <= mem_wdata[g];
        rd_age <= mem_rd[g] ? rd_age + 4'd1 : 4'd0;
      end
    end
    assign mem_rdata[g] = (mem_rd[g] && rd_age == 4'(GL - 1)) ? mem[mem_addr[g]] : ~mem[mem_addr[g]];
  end

  // Model: an access granted at edge t0 owns the bus for edges t0..t0+L,
  // strobes through t0+L-1, done at t0+L, next grant no earlier than t0+L+2.
  bit         m_act [2];
  int         m_t0 [2];
  bit         m_own [2];
  bit         m_we [2];
  bit         m_last [2];
  logic [4:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rcpu [2];
  logic [7:0] m_rdbg [2];
  logic [7:0] mm [2][32];
  int         cyc;
  bit         pgc [2];
  bit         pgd [2];
  int         gc0[$];
  int         gc1[$];
  bit         go0[$];

  task automatic model_reset(input int k);
    m_act[k] = 1'b0; m_t0[k] = 0; m_own[k] = 1'b0; m_we[k] = 1'b0; m_last[k] = 1'b1;
    m_addr[k] = 5'h00; m_wd[k] = 8'h00; m_rcpu[k] = 8'h00; m_rdbg[k] = 8'h00;
    for (int i = 0; i < 32; i++) mm[k][i] = init_val(5'(i));
  endtask

  task automatic model_step(input int k, input int e);
    int  l;
    bit  w;
    l = lat_of(k);
    if (m_act[k] && e == m_t0[k] + l) begin
      if (m_we[k]) mm[k][m_addr[k]] = m_wd[k];
      else if (m_own[k]) m_rdbg[k] = mm[k][m_addr[k]];
      else m_rcpu[k] = mm[k][m_addr[k]];
    end
    if ((!m_act[k] || e >= m_t0[k] + l + 2) && (cpu_req[k] || dbg_req[k])) begin
      w = (cpu_req[k] && (!dbg_req[k] || m_last[k])) ? 1'b0 : 1'b1;
      m_own[k]  = w;
      m_we[k]   = w ? dbg_we[k] : cpu_we[k];
      m_addr[k] = w ? dbg_addr[k] : cpu_addr[k];
      m_wd[k]   = w ? dbg_wdata[k] : cpu_wdata[k];
      m_t0[k]   = e;
      m_act[k]  = 1'b1;
      m_last[k] = w;
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  initial begin
    int l;
    bit inw, strb, dn;
    logic [6:0] exp_ctl, act_ctl;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k); pgc[k] = 1'b0; pgd[k] = 1'b0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!reset) model_reset(k);
        l    = lat_of(k);
        inw  = m_act[k] && cyc >= m_t0[k] && cyc <= m_t0[k] + l;
        strb = m_act[k] && cyc >= m_t0[k] && cyc < m_t0[k] + l;
        dn   = m_act[k] && cyc == m_t0[k] + l;
        exp_ctl = {inw && !m_own[k], inw && m_own[k], dn && !m_own[k], dn && m_own[k],
                   strb && !m_we[k], strb && m_we[k], inw};
        act_ctl = {cpu_gnt[k], dbg_gnt[k], cpu_done[k], dbg_done[k], mem_rd[k], mem_wr[k], busy[k]};
        check($sformatf("ctl%0d gnt/done/rd/wr/busy", k), 64'(act_ctl), 64'(exp_ctl));
        check($sformatf("bus%0d addr/wdata", k), 64'({mem_addr[k], mem_wdata[k]}), 64'({m_addr[k], m_wd[k]}));
        check($sformatf("rdata%0d cpu/dbg", k), 64'({cpu_rdata[k], dbg_rdata[k]}), 64'({m_rcpu[k], m_rdbg[k]}));
        if (cpu_gnt[k] && !pgc[k]) begin
          if (k == 0) begin gc0.push_back(cyc); go0.push_back(1'b0); end
          else gc1.push_back(cyc);
        end
        if (dbg_gnt[k] && !pgd[k] && k == 0) begin gc0.push_back(cyc); go0.push_back(1'b1); end
        pgc[k] = cpu_gnt[k];
        pgd[k] = dbg_gnt[k];
        if (reset) model_step(k, cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int k, input bit dbg);
    int n = 0;
    while (!(dbg ? dbg_done[k] : cpu_done[k]) && n < 40) begin
      tick();
      n++;
    end
    check("wait_done", 64'(dbg ? dbg_done[k] : cpu_done[k]), 64'd1);
    if (dbg) dbg_req[k] = 1'b0;
    else cpu_req[k] = 1'b0;
  endtask

  // Directed stimulus; inputs change just after the rising edge
  initial begin
    reset = 1'b0;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    tick();
    check("reset_outputs", 64'({cpu_gnt[0], dbg_gnt[0], mem_rd[0], mem_wr[0], busy[0], cpu_rdata[0]}), 64'd0);

    // CPU read of 1F
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 5'h1F;
    tick();
    check("t1_grant", 64'({cpu_gnt[0], mem_rd[0], mem_addr[0]}), 64'({1'b1, 1'b1, 5'h1F}));
    check("t1_dbg_quiet", 64'({dbg_gnt[0], dbg_done[0]}), 64'd0);
    tick();
    check("t1_edge2", 64'({mem_rd[0], cpu_done[0]}), 64'({1'b1, 1'b0}));
    tick();
    check("t1_done", 64'({mem_rd[0], cpu_done[0], cpu_gnt[0], cpu_rdata[0]}), 64'({1'b0, 1'b1, 1'b1, 8'hA5}));
    cpu_req[0] = 1'b0;
    tick();
    check("t1_release", 64'({cpu_gnt[0], cpu_done[0], busy[0], dbg_rdata[0]}), 64'd0);

    // Debug write of 3C to 03
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = 5'h03; dbg_wdata[0] = 8'h3C;
    tick();
    check("t2_grant", 64'({dbg_gnt[0], mem_wr[0], mem_rd[0], mem_addr[0], mem_wdata[0]}),
          64'({1'b1, 1'b1, 1'b0, 5'h03, 8'h3C}));
    tick();
    check("t2_edge2", 64'({mem_wr[0], dbg_done[0]}), 64'({1'b1, 1'b0}));
    tick();
    check("t2_done", 64'({mem_wr[0], dbg_done[0], cpu_rdata[0], dbg_rdata[0]}), 64'({1'b0, 1'b1, 8'hA5, 8'h00}));
    dbg_req[0] = 1'b0; dbg_we[0] = 1'b0;
    tick();
    check("t2_release", 64'({dbg_done[0], dbg_gnt[0]}), 64'd0);

    // Both requesters held, all reads: alternate CPU, DBG every 4 cycles
    gc0.delete(); go0.delete();
    cpu_req[0] = 1'b1; cpu_addr[0] = 5'h03; dbg_req[0] = 1'b1; dbg_addr[0] = 5'h1F;
    repeat (13) tick();
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    repeat (6) tick();
    check("t3_grant_count", 64'(gc0.size()), 64'd4);
    if (gc0.size() == 4) begin
      check("t3_order", 64'({go0[0], go0[1], go0[2], go0[3]}), 64'(4'b0101));
      for (int i = 1; i < 4; i++) check("t3_spacing", 64'(gc0[i] - gc0[i-1]), 64'd4);
    end
    check("t3_rdata", 64'({cpu_rdata[0], dbg_rdata[0]}), 64'({8'h3C, 8'hA5}));

    // Request dropped and address changed right after the grant
    cpu_req[0] = 1'b1; cpu_addr[0] = 5'h0A;
    tick();
    cpu_req[0] = 1'b0; cpu_addr[0] = 5'h00;
    tick();
    check("t4_addr_held", 64'({mem_addr[0], mem_rd[0]}), 64'({5'h0A, 1'b1}));
    tick();
    check("t4_done", 64'({cpu_done[0], cpu_rdata[0]}), 64'({1'b1, 8'h36}));
    tick();

    // Reset pulsed during an access
    cpu_req[0] = 1'b1; cpu_addr[0] = 5'h1F;
    tick();
    check("t5_access", 64'(mem_rd[0]), 64'd1);
    #2 reset = 1'b0;
    #1 check("t5_async_drop", 64'({mem_rd[0], cpu_gnt[0], busy[0]}), 64'd0);
    cpu_req[0] = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    tick();
    check("t5_no_done", 64'({cpu_done[0], cpu_rdata[0]}), 64'd0);
    cpu_req[0] = 1'b1; cpu_addr[0] = 5'h05; dbg_req[0] = 1'b1; dbg_addr[0] = 5'h06;
    tick();
    check("t5_cpu_first", 64'({cpu_gnt[0], dbg_gnt[0]}), 64'({1'b1, 1'b0}));
    wait_done(0, 1'b0);
    wait_done(0, 1'b1);
    repeat (3) tick();

    // LAT=1 instance: single strobe cycle, one access per 3 cycles under load
    gc1.delete();
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 5'h1F;
    tick();
    check("t6_grant", 64'({cpu_gnt[1], mem_rd[1], cpu_done[1]}), 64'({1'b1, 1'b1, 1'b0}));
    tick();
    check("t6_done", 64'({mem_rd[1], cpu_done[1], cpu_rdata[1]}), 64'({1'b0, 1'b1, 8'hA5}));
    repeat (8) tick();
    cpu_req[1] = 1'b0;
    repeat (4) tick();
    check("t6_grant_count", 64'(gc1.size()), 64'd4);
    if (gc1.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t6_spacing", 64'(gc1[i] - gc1[i-1]), 64'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
